// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared constants and control-word layout for the pipeline registers
//
// Purpose: default PCs, control-word field offsets/widths, dm_rn encoding.
// Ports:   none (package).
package pipe_pkg;

  localparam logic [31:0] DEF_RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] DEF_HANDLER_PC = 32'h0000_4180;

  // Control-word layout, LSB first. Total used width is 23 bits, bit 23 spare.
  localparam int DM_WRITE_MODE_LSB = 0;   localparam int DM_WRITE_MODE_W = 2;
  localparam int DM_READ_MODE_LSB  = 2;   localparam int DM_READ_MODE_W  = 3;
  localparam int DM_WE_BIT         = 5;
  localparam int DM_RE_BIT         = 6;
  localparam int F_D2_M_BIT        = 7;
  localparam int RF_WA_SEL_LSB     = 8;   localparam int RF_WA_SEL_W     = 2;
  localparam int RF_WE_BIT         = 10;
  localparam int RF_WD_SEL_LSB     = 11;  localparam int RF_WD_SEL_W     = 3;
  localparam int E_CODE_LSB        = 14;  localparam int E_CODE_W        = 5;
  localparam int BD_BIT            = 19;
  localparam int CP0_WE_BIT        = 20;
  localparam int MTC0_FLAG_BIT     = 21;
  localparam int EXL_RESET_BIT     = 22;
  localparam int CTRL_USED_W       = 23;

  // Data-memory read (dm_rn) encoding carried in the dm_read_mode field.
  typedef enum logic [2:0] {
    DM_RN_WORD   = 3'd0,
    DM_RN_HALF   = 3'd1,
    DM_RN_HALF_U = 3'd2,
    DM_RN_BYTE   = 3'd3,
    DM_RN_BYTE_U = 3'd4
  } dm_rn_e;

endpackage

// File: rtl/pipe_sat_dec.sv
// rtl/pipe_sat_dec.sv - saturating decrement (or increment when INC=1)
//
// Purpose: y = a-1 stopping at 0, or y = a+1 stopping at all-ones.
// Ports:   a - operand (W bits), y - saturated result (W bits).
module pipe_sat_dec #(
  parameter int W   = 2,
  parameter bit INC = 1'b0
) (
  input  logic [W-1:0] a,
  output logic [W-1:0] y
);

  localparam logic [W-1:0] LIMIT = INC ? {W{1'b1}} : {W{1'b0}};

  always_comb begin
    y = a;
    if (a != LIMIT) begin
      y = INC ? (a + W'(1)) : (a - W'(1));
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - configurable inter-stage pipeline register with stall/flush/req
//
// Purpose: registers payload, control, PC, Tnew and valid between stages.
//          Edge priority: reset (async) > req_i > flush_i > stall_i > load.
// Ports:   clk, reset (async, active-low), req_i, flush_i, stall_i,
//          valid_i/pc_i/tnew_i/data_i/ctrl_i in, matching *_o registered out,
//          stall_cnt_o consecutive-stall counter (saturating).
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int          DATA_W     = 32,
  parameter int          NDATA      = 6,
  parameter int          CTRL_W     = 24,
  parameter int          TNEW_W     = 2,
  parameter bit          DEC_TNEW   = 1'b1,
  parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
  parameter logic [31:0] HANDLER_PC = DEF_HANDLER_PC,
  parameter int          SCNT_W     = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_i,
  input  logic                    flush_i,
  input  logic                    stall_i,
  input  logic                    valid_i,
  input  logic [31:0]             pc_i,
  input  logic [TNEW_W-1:0]       tnew_i,
  input  logic [NDATA*DATA_W-1:0] data_i,
  input  logic [CTRL_W-1:0]       ctrl_i,
  output logic                    valid_o,
  output logic [31:0]             pc_o,
  output logic [TNEW_W-1:0]       tnew_o,
  output logic [NDATA*DATA_W-1:0] data_o,
  output logic [CTRL_W-1:0]       ctrl_o,
  output logic [SCNT_W-1:0]       stall_cnt_o
);

  logic [TNEW_W-1:0] tnew_ld;
  logic [SCNT_W-1:0] stall_cnt_next;

  generate
    if (DEC_TNEW) begin : g_tnew_dec
      pipe_sat_dec #(.W(TNEW_W), .INC(1'b0)) u_tnew_dec (
        .a (tnew_i),
        .y (tnew_ld)
      );
    end else begin : g_tnew_pass
      assign tnew_ld = tnew_i;
    end
  endgenerate

  pipe_sat_dec #(.W(SCNT_W), .INC(1'b1)) u_stall_inc (
    .a (stall_cnt_o),
    .y (stall_cnt_next)
  );

  // Every bubble path zeroes ctrl and tnew together with valid, so a squashed
  // slot can never carry a write enable or a stale hazard count downstream.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_o     <= 1'b0;
      pc_o        <= RESET_PC;
      tnew_o      <= '0;
      data_o      <= '0;
      ctrl_o      <= '0;
      stall_cnt_o <= '0;
    end else if (req_i) begin
      valid_o     <= 1'b0;
      pc_o        <= HANDLER_PC;
      tnew_o      <= '0;
      ctrl_o      <= '0;
      stall_cnt_o <= '0;
    end else if (flush_i) begin
      // PC still follows the input so EPC/bd sourcing stays meaningful.
      valid_o     <= 1'b0;
      pc_o        <= pc_i;
      tnew_o      <= '0;
      ctrl_o      <= '0;
      stall_cnt_o <= '0;
    end else if (stall_i) begin
      stall_cnt_o <= stall_cnt_next;
    end else begin
      valid_o     <= valid_i;
      pc_o        <= pc_i;
      data_o      <= data_i;
      ctrl_o      <= valid_i ? ctrl_i : '0;
      tnew_o      <= valid_i ? tnew_ld : '0;
      stall_cnt_o <= '0;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - directed self-checking bench for pipe_stage_reg
module tb_pipe_stage_reg;

  localparam int DATA_W = 32;
  localparam int NDATA  = 6;
  localparam int CTRL_W = 24;
  localparam int TNEW_W = 2;
  localparam int SCNT_W = 8;
  localparam int DW     = NDATA * DATA_W;

  logic              clk;
  logic              reset;
  logic              req_i, flush_i, stall_i, valid_i;
  logic [31:0]       pc_i;
  logic [TNEW_W-1:0] tnew_i;
  logic [DW-1:0]     data_i;
  logic [CTRL_W-1:0] ctrl_i;
  logic              valid_o;
  logic [31:0]       pc_o;
  logic [TNEW_W-1:0] tnew_o;
  logic [DW-1:0]     data_o;
  logic [CTRL_W-1:0] ctrl_o;
  logic [SCNT_W-1:0] stall_cnt_o;

  int n_cmp = 0;
  int n_err = 0;

  pipe_stage_reg #(
    .DATA_W(DATA_W), .NDATA(NDATA), .CTRL_W(CTRL_W), .TNEW_W(TNEW_W),
    .DEC_TNEW(1'b1), .RESET_PC(32'h0000_3000), .HANDLER_PC(32'h0000_4180),
    .SCNT_W(SCNT_W)
  ) dut (
    .clk(clk), .reset(reset), .req_i(req_i), .flush_i(flush_i),
    .stall_i(stall_i), .valid_i(valid_i), .pc_i(pc_i), .tnew_i(tnew_i),
    .data_i(data_i), .ctrl_i(ctrl_i), .valid_o(valid_o), .pc_o(pc_o),
    .tnew_o(tnew_o), .data_o(data_o), .ctrl_o(ctrl_o),
    .stall_cnt_o(stall_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk_data(input logic [31:0] seed);
    logic [DW-1:0] d;
    d = '0;
    for (int k = 0; k < NDATA; k++)
      d[k*DATA_W +: DATA_W] = seed ^ (32'h0101_0101 * 32'(k));
    return d;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc,
                       input logic [TNEW_W-1:0] tn, input logic [CTRL_W-1:0] c,
                       input logic [DW-1:0] d);
    valid_i = v; pc_i = pc; tnew_i = tn; ctrl_i = c; data_i = d;
  endtask

  initial begin
    reset = 1'b0; req_i = 1'b0; flush_i = 1'b0; stall_i = 1'b0;
    drive(1'b1, 32'h1234_5678, 2'd3, 24'hFFFFFF, {DW{1'b1}});
    step(); step();
    check("rst_valid", DW'(valid_o), DW'(1'b0));
    check("rst_pc",    DW'(pc_o),    DW'(32'h3000));
    check("rst_tnew",  DW'(tnew_o),  DW'(2'd0));
    check("rst_data",  data_o,       '0);
    check("rst_ctrl",  DW'(ctrl_o),  DW'(24'h0));
    check("rst_scnt",  DW'(stall_cnt_o), DW'(8'd0));
    reset = 1'b1;

    // Load with Tnew decrement.
    drive(1'b1, 32'h3010, 2'd2, 24'h000ABC, mk_data(32'hD1D1_0001));
    step();
    check("ld1_tnew",  DW'(tnew_o),  DW'(2'd1));
    check("ld1_pc",    DW'(pc_o),    DW'(32'h3010));
    check("ld1_ctrl",  DW'(ctrl_o),  DW'(24'h000ABC));
    check("ld1_valid", DW'(valid_o), DW'(1'b1));
    check("ld1_data",  data_o,       mk_data(32'hD1D1_0001));

    drive(1'b1, 32'h3014, 2'd0, 24'h000ABC, mk_data(32'hD2D2_0002));
    step();
    check("ld2_tnew_sat0", DW'(tnew_o), DW'(2'd0));
    check("ld2_data",      data_o,      mk_data(32'hD2D2_0002));

    drive(1'b1, 32'h3018, 2'd3, 24'h000ABC, mk_data(32'hD3D3_0003));
    step();
    check("ld3_tnew", DW'(tnew_o), DW'(2'd2));

    // Long stall with changing inputs: outputs must hold, counter saturates.
    stall_i = 1'b1;
    drive(1'b0, 32'hDEAD_BEEF, 2'd1, 24'h555555, mk_data(32'hBAD0_BAD0));
    for (int n = 1; n <= 300; n++) begin
      step();
      if (n == 1)   check("stall_cnt_1",   DW'(stall_cnt_o), DW'(8'd1));
      if (n == 254) check("stall_cnt_254", DW'(stall_cnt_o), DW'(8'd254));
      if (n == 255) check("stall_cnt_255", DW'(stall_cnt_o), DW'(8'd255));
      if (n == 256) check("stall_cnt_256", DW'(stall_cnt_o), DW'(8'd255));
      if (n == 150) check("stall_mid_pc",  DW'(pc_o),        DW'(32'h3018));
    end
    check("stall_cnt_300", DW'(stall_cnt_o), DW'(8'd255));
    check("stall_valid",   DW'(valid_o),     DW'(1'b1));
    check("stall_pc",      DW'(pc_o),        DW'(32'h3018));
    check("stall_tnew",    DW'(tnew_o),      DW'(2'd2));
    check("stall_ctrl",    DW'(ctrl_o),      DW'(24'h000ABC));
    check("stall_data",    data_o,           mk_data(32'hD3D3_0003));

    // Release: counter clears on the first non-stall edge.
    stall_i = 1'b0;
    drive(1'b1, 32'h301C, 2'd3, 24'h000123, mk_data(32'hD4D4_0004));
    step();
    check("rel_scnt", DW'(stall_cnt_o), DW'(8'd0));
    check("rel_pc",   DW'(pc_o),        DW'(32'h301C));
    check("rel_tnew", DW'(tnew_o),      DW'(2'd2));

    // Short stall, then flush while stalled.
    stall_i = 1'b1;
    step(); step(); step();
    check("stall3_cnt", DW'(stall_cnt_o), DW'(8'd3));
    flush_i = 1'b1;
    drive(1'b1, 32'h3020, 2'd3, 24'h00FFFF, mk_data(32'hEEEE_0005));
    step();
    check("fl_valid", DW'(valid_o),     DW'(1'b0));
    check("fl_ctrl",  DW'(ctrl_o),      DW'(24'h0));
    check("fl_tnew",  DW'(tnew_o),      DW'(2'd0));
    check("fl_pc",    DW'(pc_o),        DW'(32'h3020));
    check("fl_data",  data_o,           mk_data(32'hD4D4_0004));
    check("fl_scnt",  DW'(stall_cnt_o), DW'(8'd0));
    flush_i = 1'b0; stall_i = 1'b0;

    // Load, stall twice, then req with flush and stall.
    drive(1'b1, 32'h3024, 2'd2, 24'h000555, mk_data(32'hD5D5_0006));
    step();
    stall_i = 1'b1;
    step(); step();
    req_i = 1'b1; flush_i = 1'b1;
    drive(1'b1, 32'h3028, 2'd3, 24'h00AAAA, mk_data(32'hEEEE_0007));
    step();
    check("rq_pc",    DW'(pc_o),        DW'(32'h4180));
    check("rq_valid", DW'(valid_o),     DW'(1'b0));
    check("rq_ctrl",  DW'(ctrl_o),      DW'(24'h0));
    check("rq_tnew",  DW'(tnew_o),      DW'(2'd0));
    check("rq_scnt",  DW'(stall_cnt_o), DW'(8'd0));
    check("rq_data",  data_o,           mk_data(32'hD5D5_0006));
    req_i = 1'b0; flush_i = 1'b0; stall_i = 1'b0;

    drive(1'b1, 32'h302C, 2'd2, 24'h000777, mk_data(32'hD6D6_0008));
    step();
    check("post_rq_pc",    DW'(pc_o),    DW'(32'h302C));
    check("post_rq_valid", DW'(valid_o), DW'(1'b1));
    check("post_rq_tnew",  DW'(tnew_o),  DW'(2'd1));
    check("post_rq_ctrl",  DW'(ctrl_o),  DW'(24'h000777));

    // Load of an invalid slot: ctrl and tnew forced to zero, data passes.
    drive(1'b0, 32'h3030, 2'd3, 24'h000FFF, mk_data(32'hD7D7_0009));
    step();
    check("inv_ctrl",  DW'(ctrl_o),  DW'(24'h0));
    check("inv_tnew",  DW'(tnew_o),  DW'(2'd0));
    check("inv_valid", DW'(valid_o), DW'(1'b0));
    check("inv_data",  data_o,       mk_data(32'hD7D7_0009));
    check("inv_pc",    DW'(pc_o),    DW'(32'h3030));

    // Asynchronous reset asserted mid-cycle, observed before the next edge.
    drive(1'b1, 32'h3034, 2'd2, 24'h000321, {DW{1'b1}});
    step();
    stall_i = 1'b1;
    step();
    check("pre_ar_scnt", DW'(stall_cnt_o), DW'(8'd1));
    #2 reset = 1'b0;
    #1;
    check("ar_pc",    DW'(pc_o),        DW'(32'h3000));
    check("ar_valid", DW'(valid_o),     DW'(1'b0));
    check("ar_data",  data_o,           '0);
    check("ar_ctrl",  DW'(ctrl_o),      DW'(24'h0));
    check("ar_tnew",  DW'(tnew_o),      DW'(2'd0));
    check("ar_scnt",  DW'(stall_cnt_o), DW'(8'd0));
    step();
    reset = 1'b1; stall_i = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
